// File: rtl/rst_req_pkg.sv
// -----------------------------------------------------------------------------
// rst_req_pkg
// Shared definitions for the fabric reset request initiator.
//   - sequencer state encoding
//   - bit positions inside ERR_STATUS and RST_CAUSE
//   - small elaboration-time helper for counter sizing
// -----------------------------------------------------------------------------
package rst_req_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    RELEASE = 2'd2,
    HOLDOFF = 2'd3
  } rst_req_state_t;

  // ERR_STATUS bit positions
  localparam int ERR_NO_FALL     = 0;
  localparam int ERR_REL_TIMEOUT = 1;
  localparam int ERR_DROPPED     = 2;
  localparam int ERR_W           = 3;

  // RST_CAUSE bit positions
  localparam int CAUSE_SW   = 0;
  localparam int CAUSE_WDOG = 1;
  localparam int CAUSE_W    = 2;

  // Largest of three cycle counts; the shared phase counter must hold any of them.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/rst_req_sync.sv
// -----------------------------------------------------------------------------
// rst_req_sync
// Multi-flop bit synchronizer for a level that is asynchronous to CLK.
// Flops take RST_VAL on a synchronous, active-high RST.
//
// Parameters:
//   STAGES  - number of flops in the chain (>= 1); latency is STAGES cycles
//   RST_VAL - value loaded into every flop on reset
// Ports:
//   CLK      in   sampling clock
//   RST      in   synchronous active-high reset
//   ASYNC_IN in   asynchronous input level
//   SYNC_OUT out  synchronized level (last flop of the chain)
// -----------------------------------------------------------------------------
module rst_req_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic CLK,
  input  logic RST,
  input  logic ASYNC_IN,
  output logic SYNC_OUT
);

  if (STAGES < 1) begin : g_bad_stages
    $error("rst_req_sync: STAGES must be at least 1");
  end

  logic [STAGES-1:0] stg_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      stg_q <= {STAGES{RST_VAL}};
    end else begin
      stg_q[0] <= ASYNC_IN;
      for (int i = 1; i < STAGES; i++) begin
        stg_q[i] <= stg_q[i-1];
      end
    end
  end

  assign SYNC_OUT = stg_q[STAGES-1];

endmodule

// File: rtl/reset_request_initiator.sv
// -----------------------------------------------------------------------------
// reset_request_initiator
// Initiator side of the fabric reset handshake. Accepts software and watchdog
// reset requests, drives a fixed-width active-low request into the reset
// controller, confirms FABRIC_RESET_N falls and then rises again, and reports
// cause, completion and sticky errors. Lives in the always-on domain so it
// survives the fabric reset it asks for.
//
// Build option:
//   RSTREQ_WDOG_EN - when defined, WDOG_EXPIRE acts as a request source.
//                    When undefined, WDOG_EXPIRE is ignored entirely (no
//                    request, no drop flag) and RST_CAUSE[1] stays 0.
//
// Parameters:
//   ASSERT_CYCLES  - cycles EXT_RST_N is held low (>= SYNC_STAGES+2)
//   ACK_TIMEOUT    - max cycles in RELEASE waiting for FABRIC_RESET_N high
//   HOLDOFF_CYCLES - dead time after completion before new requests
//   SYNC_STAGES    - synchronizer depth on FABRIC_RESET_N
// Ports:
//   CLK            in   free-running clock
//   RST            in   synchronous active-high reset (POR-derived)
//   SW_RST_REQ     in   software request pulse
//   WDOG_EXPIRE    in   watchdog request pulse
//   ERR_CLR        in   clears ERR_STATUS (a same-cycle set wins)
//   FABRIC_RESET_N in   controller fabric reset, async to CLK
//   EXT_RST_N      out  registered active-low request to the controller
//   BUSY           out  high whenever the sequencer is not idle
//   DONE           out  one-cycle pulse on successful completion
//   RST_CAUSE[1:0] out  cause of last accepted request {wdog, sw}
//   ERR_STATUS[2:0] out sticky {dropped, release timeout, no fall}
//
// State table
//   state   | meaning
//   IDLE    | waiting for a request
//   ASSERT  | EXT_RST_N low for ASSERT_CYCLES, watching for fabric reset fall
//   RELEASE | EXT_RST_N high, waiting up to ACK_TIMEOUT for fabric reset rise
//   HOLDOFF | dead time after success; requests here are dropped
// -----------------------------------------------------------------------------
module reset_request_initiator
  import rst_req_pkg::*;
#(
  parameter int ASSERT_CYCLES  = 32,
  parameter int ACK_TIMEOUT    = 1024,
  parameter int HOLDOFF_CYCLES = 64,
  parameter int SYNC_STAGES    = 2
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               SW_RST_REQ,
  input  logic               WDOG_EXPIRE,
  input  logic               ERR_CLR,
  input  logic               FABRIC_RESET_N,
  output logic               EXT_RST_N,
  output logic               BUSY,
  output logic               DONE,
  output logic [CAUSE_W-1:0] RST_CAUSE,
  output logic [ERR_W-1:0]   ERR_STATUS
);

  // The fall must be able to cross the synchronizer before ASSERT ends.
  if (ASSERT_CYCLES < SYNC_STAGES + 2) begin : g_bad_assert_cycles
    $error("reset_request_initiator: ASSERT_CYCLES must be >= SYNC_STAGES+2");
  end
  if (ACK_TIMEOUT < 1) begin : g_bad_ack_timeout
    $error("reset_request_initiator: ACK_TIMEOUT must be >= 1");
  end
  if (HOLDOFF_CYCLES < 1) begin : g_bad_holdoff
    $error("reset_request_initiator: HOLDOFF_CYCLES must be >= 1");
  end

  // One down-counter serves every timed phase; it is sized for the longest one.
  localparam int CNT_MAX = max3(ASSERT_CYCLES, ACK_TIMEOUT, HOLDOFF_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef logic [CNT_W-1:0] cnt_t;

  // Loaded on phase entry; the phase ends on the cycle the counter reads 0,
  // so a load of N-1 gives exactly N cycles in the phase.
  localparam cnt_t LOAD_ASSERT  = cnt_t'(ASSERT_CYCLES - 1);
  localparam cnt_t LOAD_RELEASE = cnt_t'(ACK_TIMEOUT - 1);
  localparam cnt_t LOAD_HOLDOFF = cnt_t'(HOLDOFF_CYCLES - 1);
  localparam cnt_t CNT_ZERO     = '0;
  localparam cnt_t CNT_ONE      = cnt_t'(1);

  rst_req_state_t     state_q, state_nxt;
  cnt_t               cnt_q, cnt_nxt;
  logic               seen_low_q, seen_low_nxt;
  logic               ext_rst_n_q, ext_rst_n_nxt;
  logic               done_q, done_nxt;
  logic [CAUSE_W-1:0] cause_q, cause_nxt;
  logic [ERR_W-1:0]   err_q, err_nxt, err_set;

  logic               fr_s;
  logic               wdog_eff;
  logic [CAUSE_W-1:0] req_vec;
  logic               req_any;
  logic               fall_seen;

  rst_req_sync #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b1)
  ) u_fr_sync (
    .CLK      (CLK),
    .RST      (RST),
    .ASYNC_IN (FABRIC_RESET_N),
    .SYNC_OUT (fr_s)
  );

`ifdef RSTREQ_WDOG_EN
  assign wdog_eff = WDOG_EXPIRE;
`else
  // Port kept for a stable footprint; it has no effect in this build.
  logic wdog_unused;
  assign wdog_unused = WDOG_EXPIRE;
  assign wdog_eff    = 1'b0;
`endif

  assign req_vec[CAUSE_SW]   = SW_RST_REQ;
  assign req_vec[CAUSE_WDOG] = wdog_eff;
  assign req_any             = |req_vec;

  // Include the current sample so a fall seen on the last ASSERT cycle counts.
  assign fall_seen = seen_low_q | ~fr_s;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      cnt_q       <= CNT_ZERO;
      seen_low_q  <= 1'b0;
      ext_rst_n_q <= 1'b1;
      done_q      <= 1'b0;
      cause_q     <= '0;
      err_q       <= '0;
    end else begin
      state_q     <= state_nxt;
      cnt_q       <= cnt_nxt;
      seen_low_q  <= seen_low_nxt;
      ext_rst_n_q <= ext_rst_n_nxt;
      done_q      <= done_nxt;
      cause_q     <= cause_nxt;
      err_q       <= err_nxt;
    end
  end

  always_comb begin
    state_nxt    = state_q;
    cnt_nxt      = cnt_q;
    seen_low_nxt = seen_low_q;
    done_nxt     = 1'b0;
    cause_nxt    = cause_q;
    err_set      = '0;

    case (state_q)
      IDLE: begin
        if (req_any) begin
          state_nxt    = ASSERT;
          cnt_nxt      = LOAD_ASSERT;
          seen_low_nxt = 1'b0;
          cause_nxt    = req_vec;
        end
      end

      ASSERT: begin
        if (!fr_s) begin
          seen_low_nxt = 1'b1;
        end
        if (cnt_q == CNT_ZERO) begin
          if (fall_seen) begin
            state_nxt = RELEASE;
            cnt_nxt   = LOAD_RELEASE;
          end else begin
            err_set[ERR_NO_FALL] = 1'b1;
            state_nxt            = IDLE;
          end
        end else begin
          cnt_nxt = cnt_q - CNT_ONE;
        end
      end

      RELEASE: begin
        if (fr_s) begin
          done_nxt  = 1'b1;
          state_nxt = HOLDOFF;
          cnt_nxt   = LOAD_HOLDOFF;
        end else if (cnt_q == CNT_ZERO) begin
          err_set[ERR_REL_TIMEOUT] = 1'b1;
          state_nxt                = IDLE;
        end else begin
          cnt_nxt = cnt_q - CNT_ONE;
        end
      end

      HOLDOFF: begin
        if (cnt_q == CNT_ZERO) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt_q - CNT_ONE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    if ((state_q != IDLE) && req_any) begin
      err_set[ERR_DROPPED] = 1'b1;
    end

    // Set has priority over clear.
    err_nxt = (ERR_CLR ? '0 : err_q) | err_set;

    // Registered so the request pin is glitch-free and aligned with the state.
    ext_rst_n_nxt = (state_nxt != ASSERT);
  end

  assign EXT_RST_N  = ext_rst_n_q;
  assign BUSY       = (state_q != IDLE);
  assign DONE       = done_q;
  assign RST_CAUSE  = cause_q;
  assign ERR_STATUS = err_q;

endmodule
